sample_data_buf: RTL

- Parametrised successor to the real-time feedback sampler.
- On doSample, captures a timestamp, NUM_GLOBAL global quadlets and NUM_OFFSETS quadlets per channel for NUM_CHAN channels into a double-buffered (ping-pong) block.
- The Firewire/Ethernet block-read engine reads a coherent, stable bank while the next sample is captured into the other bank.
- Sits between the board register muxes and the packet block-read path.

---
 rtl/sample_data_buf_pkg.sv | 28 ++
 rtl/sample_data_buf_ram.sv | 29 ++
 rtl/sample_data_buf.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sample_data_buf_pkg.sv
// Shared constants and types for the double-buffered real-time sample block.
package sample_data_buf_pkg;

  localparam int unsigned NUM_CHAN_DEF    = 4;
  localparam int unsigned NUM_GLOBAL_DEF  = 3;
  localparam int unsigned NUM_OFFSETS_DEF = 6;

  // Per-channel quadlet offsets, in block order
  localparam int unsigned OFF_ADC    = 0;
  localparam int unsigned OFF_POS    = 1;
  localparam int unsigned OFF_PERIOD = 2;
  localparam int unsigned OFF_QTR1   = 3;
  localparam int unsigned OFF_QTR5   = 4;
  localparam int unsigned OFF_RUN    = 5;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } cap_state_t;

  // Quadlets in one RT block: timestamp + globals + per-channel data
  function automatic int unsigned rt_block_quads(input int unsigned nc,
                                                 input int unsigned ng,
                                                 input int unsigned no);
    return 1 + ng + nc * no;
  endfunction

endpackage

// File: rtl/sample_data_buf_ram.sv
// Two-bank sample RAM: multi-port synchronous write into one bank, async read.
module sample_bank_ram #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_WR     = 10
) (
  input  logic                         clk,
  input  logic                         wr_bank,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*32-1:0]         wr_data,
  input  logic                         rd_bank,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic [31:0]                  rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem [2][DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      if (wr_en[i])
        mem[wr_bank][wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[i*32 +: 32];
    end
  end

  assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/sample_data_buf.sv
// Ping-pong RT sample buffer: captures timestamp, globals and per-channel data
// into the back bank while the block-read path reads a stable front bank.
module sample_data_buf
  import sample_data_buf_pkg::*;
#(
  parameter int unsigned NUM_CHAN    = NUM_CHAN_DEF,
  parameter int unsigned NUM_GLOBAL  = NUM_GLOBAL_DEF,
  parameter int unsigned NUM_OFFSETS = NUM_OFFSETS_DEF,
  parameter int unsigned ADDR_WIDTH  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      doSample,
  input  logic [32*NUM_GLOBAL-1:0]  glob_in,
  output logic [3:0]                chan,
  input  logic [32*NUM_OFFSETS-1:0] chan_data,
  input  logic                      blk_lock,
  input  logic [ADDR_WIDTH-1:0]     blk_addr,
  output logic [31:0]               blk_data,
  output logic                      isBusy,
  output logic                      sample_valid,
  output logic                      swap_pending,
  output logic [7:0]                miss_count,
  output logic [31:0]               timestamp
);

  localparam int unsigned QUADS    = rt_block_quads(NUM_CHAN, NUM_GLOBAL, NUM_OFFSETS);
  localparam int unsigned NUM_WR   = NUM_OFFSETS + 1 + NUM_GLOBAL;
  localparam logic [4:0]  LAST_CNT = 5'(NUM_CHAN + 1);

  cap_state_t state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic       capture, done, first, publish;
  logic       rd_sel;

  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WR*32-1:0]         wr_data;
  logic [31:0]                  ram_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (doSample) begin
          state_nxt = ST_BUSY;
          cnt_nxt   = 5'd1;
        end
      end
      ST_BUSY: begin
        if (cnt == LAST_CNT) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          capture = 1'b1;
          cnt_nxt = cnt + 5'd1;
        end
      end
      default: ;
    endcase
  end

  // Counter is one bit wider so NUM_CHAN=15 can reach its completion value
  assign chan   = cnt[3:0];
  assign isBusy = (state == ST_BUSY);
  assign first  = capture && (cnt == 5'd1);

  // A pending swap waits for the reader and never exposes a half-written bank
  assign publish = !blk_lock && (done || (swap_pending && !isBusy));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timestamp    <= '0;
      rd_sel       <= 1'b0;
      sample_valid <= 1'b0;
      swap_pending <= 1'b0;
      miss_count   <= '0;
    end else begin
      timestamp <= first ? '0 : timestamp + 32'd1;
      if (doSample && isBusy && (miss_count != 8'hFF))
        miss_count <= miss_count + 8'd1;
      if (publish) begin
        rd_sel       <= ~rd_sel;
        sample_valid <= 1'b1;
        swap_pending <= 1'b0;
      end else if (done) begin
        swap_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int unsigned o = 0; o < NUM_OFFSETS; o++) begin
      wr_en[o] = capture;
      wr_addr[o*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(1 + NUM_GLOBAL + o * NUM_CHAN)
                                          + ADDR_WIDTH'(cnt) - ADDR_WIDTH'(1);
      wr_data[o*32 +: 32] = chan_data[o*32 +: 32];
    end
    wr_en[NUM_OFFSETS]                           = first;
    wr_addr[NUM_OFFSETS*ADDR_WIDTH +: ADDR_WIDTH] = '0;
    wr_data[NUM_OFFSETS*32 +: 32]                 = timestamp;
    for (int unsigned g = 0; g < NUM_GLOBAL; g++) begin
      wr_en[NUM_OFFSETS+1+g] = first;
      wr_addr[(NUM_OFFSETS+1+g)*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(1 + g);
      wr_data[(NUM_OFFSETS+1+g)*32 +: 32] = glob_in[g*32 +: 32];
    end
  end

  sample_bank_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WR     (NUM_WR)
  ) u_ram (
    .clk     (clk),
    .wr_bank (~rd_sel),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_bank (rd_sel),
    .rd_addr (blk_addr),
    .rd_data (ram_q)
  );

  assign blk_data = (sample_valid && (32'(blk_addr) < QUADS)) ? ram_q : '0;

endmodule
